// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one single-port memory.
// One access is in flight at a time. Each access ends with an ack pulse, either when the memory is ready or on timeout.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_rd_en,
    input  logic              dm_wr_en,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              freeze,
    output logic              if_stall,
    output logic              timeout_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IF_ACC = 2'd1;
    localparam logic [1:0] S_DM_ACC = 2'd2;
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]        r_state;
    logic [7:0]        r_wait;
    logic              r_pri_dm;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic              r_tmo;

    logic w_if_vld;
    logic w_dm_vld;
    logic w_grant_dm;
    logic w_grant_if;
    logic w_done;
    logic w_tmo;

    // A requester being acked this cycle is still holding its request line; ignore it.
    assign w_if_vld   = if_req & ~r_if_ack;
    assign w_dm_vld   = (dm_rd_en | dm_wr_en) & ~r_dm_ack;
    assign w_grant_dm = w_dm_vld & (~w_if_vld | r_pri_dm);
    assign w_grant_if = w_if_vld & ~w_grant_dm;
    assign w_done     = r_mem_req & mem_ready;
    assign w_tmo      = r_mem_req & ~mem_ready & (r_wait == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_pri_dm    <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_dm | w_grant_if) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_grant_dm & dm_wr_en;
                        r_mem_addr  <= w_grant_dm ? dm_addr : if_addr;
                        r_mem_wdata <= w_grant_dm ? dm_wdata : '0;
                        r_wait      <= '0;
                        r_state     <= w_grant_dm ? S_DM_ACC : S_IF_ACC;
                        // Priority alternates only when both sides contend.
                        if (w_if_vld & w_dm_vld)
                            r_pri_dm <= ~w_grant_dm;
                    end
                end
                S_IF_ACC, S_DM_ACC: begin
                    if (w_done | w_tmo) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                        if (w_tmo)
                            r_tmo <= 1'b1;
                        if (r_state == S_IF_ACC) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= w_done ? mem_rdata : '0;
                        end else begin
                            r_dm_ack   <= 1'b1;
                            r_dm_rdata <= (w_done & ~r_mem_we) ? mem_rdata : '0;
                        end
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign if_rdata    = r_if_rdata;
    assign dm_rdata    = r_dm_rdata;
    assign if_ack      = r_if_ack;
    assign dm_ack      = r_dm_ack;
    assign timeout_err = r_tmo;
    assign freeze      = (dm_rd_en | dm_wr_en) & ~r_dm_ack;
    assign if_stall    = if_req & ~r_if_ack;

endmodule
